// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants and helpers for the wait-state data memory
// and its lane unit.
//   - RISC-V funct3 size/sign codes for loads and stores
//   - FSM state encoding for dmem_ws
//   - f3_illegal / misaligned: access-fault helpers
package dmem_pkg;

  // RISC-V load/store size/sign codes
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Unknown codes are always illegal; unsigned codes are illegal for stores.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    logic bad;
    case (f3)
      F3_B, F3_H, F3_W: bad = 1'b0;
      F3_BU, F3_HU:     bad = we;
      default:          bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Halfwords need an even address; words need a 4-byte-aligned address.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic mis;
    case (f3)
      F3_H, F3_HU: mis = off[0];
      F3_W:        mis = (off != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_lane.sv
// dmem_lane: combinational byte-lane unit.
//   Store side: turns a size code and byte offset into a 4-bit byte enable,
//   and replicates the right-aligned store data across the lanes.
//   Load side: picks the addressed byte/halfword out of a 32-bit word and
//   sign- or zero-extends it.
// Ports:
//   funct3 in  3   size/sign code (already legal; unknown codes act as W)
//   off    in  2   byte offset within the word
//   wdata  in  32  right-aligned store data
//   rword  in  32  word read from storage
//   be     out 4   byte enables for the store
//   wrep   out 32  store data replicated onto every candidate lane
//   rext   out 32  extended load result
module dmem_lane
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wrep,
  output logic [31:0] rext
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Store byte enables and lane replication.
  always_comb begin
    be   = 4'b1111;
    wrep = wdata;
    case (funct3)
      F3_B: begin
        wrep = {4{wdata[7:0]}};
        case (off)
          2'b00:   be = 4'b0001;
          2'b01:   be = 4'b0010;
          2'b10:   be = 4'b0100;
          2'b11:   be = 4'b1000;
          default: be = 4'b0000;
        endcase
      end
      F3_H: begin
        wrep = {2{wdata[15:0]}};
        if (off[1]) begin
          be = 4'b1100;
        end else begin
          be = 4'b0011;
        end
      end
      default: begin
        be   = 4'b1111;
        wrep = wdata;
      end
    endcase
  end

  // Load lane selection.
  always_comb begin
    byte_s = 8'd0;
    half_s = 16'd0;
    case (off)
      2'b00:   byte_s = rword[7:0];
      2'b01:   byte_s = rword[15:8];
      2'b10:   byte_s = rword[23:16];
      2'b11:   byte_s = rword[31:24];
      default: byte_s = 8'd0;
    endcase
    if (off[1]) begin
      half_s = rword[31:16];
    end else begin
      half_s = rword[15:0];
    end
  end

  // Load sign/zero extension.
  always_comb begin
    rext = rword;
    case (funct3)
      F3_B:    rext = {{24{byte_s[7]}}, byte_s};
      F3_BU:   rext = {24'd0, byte_s};
      F3_H:    rext = {{16{half_s[15]}}, half_s};
      F3_HU:   rext = {16'd0, half_s};
      default: rext = rword;
    endcase
  end

endmodule

// File: rtl/dmem_ws.sv
// dmem_ws: word-organised, byte-addressed data RAM with RISC-V sized
// loads/stores behind a req/ready handshake and WAIT_CYC wait states.
// Optional feature macro: DMEM_WS_FAULT_EN
//   defined   -> illegal funct3 / misaligned accesses fault (err=1, no write,
//                response one cycle after acceptance)
//   undefined -> err tied low; misaligned addresses are force-aligned and
//                illegal funct3 is treated as W; every access takes WAIT_CYC
// Ports:
//   clk    in  1       clock
//   rst    in  1       synchronous active-high reset (RAM is not cleared)
//   req    in  1       access request, sampled only while idle
//   we     in  1       1 = store, 0 = load
//   funct3 in  3       size/sign code
//   addr   in  ADDR_W  byte address (wraps modulo DEPTH*4)
//   dataw  in  32      right-aligned store data
//   ready  out 1       one-cycle completion pulse
//   datar  out 32      extended load result, valid with ready
//   err    out 1       access fault, valid with ready
module dmem_ws
  import dmem_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DEPTH    = 64,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       dataw,
  output logic              ready,
  output logic [31:0]       datar,
  output logic              err
);

  localparam int   IDX_W   = $clog2(DEPTH);
  localparam logic NO_WAIT = (WAIT_CYC == 0);

  logic [31:0]       mem_r [DEPTH];

  logic [1:0]        state_r;
  logic [3:0]        cnt_r;
  logic              we_r;
  logic [2:0]        f3_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       dataw_r;
  logic              ready_r;
  logic [31:0]       datar_r;
  logic              err_r;

  logic              cur_we_s;
  logic [2:0]        cur_f3_s;
  logic [ADDR_W-1:0] cur_addr_s;
  logic [31:0]       cur_dataw_s;
  logic [2:0]        eff_f3_s;
  logic [1:0]        eff_off_s;
  logic              fault_s;
  logic              commit_s;
  logic              wr_en_s;
  logic [IDX_W-1:0]  idx_s;
  logic [31:0]       rword_s;
  logic [3:0]        be_s;
  logic [31:0]       wrep_s;
  logic [31:0]       rext_s;
  logic [31:0]       resp_data_s;

  // When idle the access may commit on its acceptance edge (fault, or no
  // wait states), so the live inputs are used; afterwards the latched copy.
  always_comb begin
    if (state_r == ST_IDLE) begin
      cur_we_s    = we;
      cur_f3_s    = funct3;
      cur_addr_s  = addr;
      cur_dataw_s = dataw;
    end else begin
      cur_we_s    = we_r;
      cur_f3_s    = f3_r;
      cur_addr_s  = addr_r;
      cur_dataw_s = dataw_r;
    end
  end

`ifdef DMEM_WS_FAULT_EN
  // Faulting accesses are flagged; the lane unit sees the raw request.
  always_comb begin
    eff_f3_s  = cur_f3_s;
    eff_off_s = cur_addr_s[1:0];
    fault_s   = f3_illegal(cur_we_s, cur_f3_s) | misaligned(cur_f3_s, cur_addr_s[1:0]);
  end
`else
  // No faults: illegal codes become W, and the offset is forced to the
  // natural alignment of the (possibly substituted) access size.
  always_comb begin
    fault_s   = 1'b0;
    eff_off_s = cur_addr_s[1:0];
    if (f3_illegal(cur_we_s, cur_f3_s)) begin
      eff_f3_s = F3_W;
    end else begin
      eff_f3_s = cur_f3_s;
    end
    case (eff_f3_s)
      F3_H, F3_HU: eff_off_s = {cur_addr_s[1], 1'b0};
      F3_W:        eff_off_s = 2'b00;
      default:     eff_off_s = cur_addr_s[1:0];
    endcase
  end
`endif

  assign idx_s   = cur_addr_s[IDX_W+1:2];
  assign rword_s = mem_r[idx_s];

  // Address bits above the word index are ignored (wrap-around).
  generate
    if (ADDR_W > IDX_W + 2) begin : g_hi_addr
      logic unused_hi_s;
      assign unused_hi_s = ^cur_addr_s[ADDR_W-1:IDX_W+2];
    end
  endgenerate

  dmem_lane u_lane (
    .funct3 (eff_f3_s),
    .off    (eff_off_s),
    .wdata  (cur_dataw_s),
    .rword  (rword_s),
    .be     (be_s),
    .wrep   (wrep_s),
    .rext   (rext_s)
  );

  // The access is performed on the edge that enters RESP: immediately on
  // acceptance for faults or zero wait states, else when the counter hits 0.
  always_comb begin
    commit_s = 1'b0;
    case (state_r)
      ST_IDLE: commit_s = req & (fault_s | NO_WAIT);
      ST_WAIT: commit_s = (cnt_r == 4'd1);
      default: commit_s = 1'b0;
    endcase
  end

  // Stores and faults return zero data.
  always_comb begin
    if (fault_s || cur_we_s) begin
      resp_data_s = 32'd0;
    end else begin
      resp_data_s = rext_s;
    end
  end

  assign wr_en_s = commit_s & cur_we_s & ~fault_s & ~rst;

  // RAM byte-lane write; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) begin
          mem_r[idx_s][8*i +: 8] <= wrep_s[8*i +: 8];
        end
      end
    end
  end

  // Handshake FSM, wait counter, request latch and registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      we_r    <= 1'b0;
      f3_r    <= 3'd0;
      addr_r  <= '0;
      dataw_r <= 32'd0;
      ready_r <= 1'b0;
      datar_r <= 32'd0;
      err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          ready_r <= 1'b0;
          datar_r <= 32'd0;
          err_r   <= 1'b0;
          if (req) begin
            we_r    <= we;
            f3_r    <= funct3;
            addr_r  <= addr;
            dataw_r <= dataw;
            if (commit_s) begin
              state_r <= ST_RESP;
              ready_r <= 1'b1;
              err_r   <= fault_s;
              datar_r <= resp_data_s;
            end else begin
              state_r <= ST_WAIT;
              cnt_r   <= 4'(WAIT_CYC);
            end
          end
        end
        ST_WAIT: begin
          cnt_r <= cnt_r - 4'd1;
          if (commit_s) begin
            state_r <= ST_RESP;
            ready_r <= 1'b1;
            err_r   <= fault_s;
            datar_r <= resp_data_s;
          end
        end
        ST_RESP: begin
          // ready is high during this state; drop it and return to idle
          state_r <= ST_IDLE;
          ready_r <= 1'b0;
          datar_r <= 32'd0;
          err_r   <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= 4'd0;
          ready_r <= 1'b0;
          datar_r <= 32'd0;
          err_r   <= 1'b0;
        end
      endcase
    end
  end

  assign ready = ready_r;
  assign datar = datar_r;
  assign err   = err_r;

endmodule

// File: tb/tb_dmem_ws.sv
// Scoreboard bench for dmem_ws: one instance with WAIT_CYC=2 (default
// geometry) and one with WAIT_CYC=0 and a wider address bus for wrap tests.
module tb_dmem_ws;
  import dmem_pkg::*;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        req2 = 1'b0, we2 = 1'b0, ready2, err2;
  logic [2:0]  f3_2 = 3'd0;
  logic [7:0]  addr2 = 8'd0;
  logic [31:0] dw2 = 32'd0, datar2;

  logic        req0 = 1'b0, we0 = 1'b0, ready0, err0;
  logic [2:0]  f3_0 = 3'd0;
  logic [11:0] addr0 = 12'd0;
  logic [31:0] dw0 = 32'd0, datar0;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   rdy_cnt2 = 0;
  exp_t q2[$];
  exp_t q0[$];

  localparam int LAT2 = 3;  // WAIT_CYC=2: ready in cycle N+3
  localparam int LAT0 = 1;  // WAIT_CYC=0
  localparam int LATF = 1;  // faults

  dmem_ws #(.ADDR_W(8), .DEPTH(64), .WAIT_CYC(2)) u2 (
    .clk(clk), .rst(rst), .req(req2), .we(we2), .funct3(f3_2), .addr(addr2),
    .dataw(dw2), .ready(ready2), .datar(datar2), .err(err2)
  );

  dmem_ws #(.ADDR_W(12), .DEPTH(64), .WAIT_CYC(0)) u0 (
    .clk(clk), .rst(rst), .req(req0), .we(we0), .funct3(f3_0), .addr(addr0),
    .dataw(dw0), .ready(ready0), .datar(datar0), .err(err0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor for the WAIT_CYC=2 instance.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && ready2 === 1'b1) begin
        rdy_cnt2++;
        if (q2.size() == 0) begin
          chk("unexpected_ready2", {31'd0, ready2}, 32'd0);
        end else begin
          e = q2.pop_front();
          chk("datar2", datar2, e.data);
          chk("err2", {31'd0, err2}, {31'd0, e.err});
          chk("latency2", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  // Monitor for the WAIT_CYC=0 instance.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && ready0 === 1'b1) begin
        if (q0.size() == 0) begin
          chk("unexpected_ready0", {31'd0, ready0}, 32'd0);
        end else begin
          e = q0.pop_front();
          chk("datar0", datar0, e.data);
          chk("err0", {31'd0, err0}, {31'd0, e.err});
          chk("latency0", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  task automatic wait_done(input int dut);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dut == 2 && q2.size() == 0) return;
      if (dut == 0 && q0.size() == 0) return;
    end
    if (dut == 2) begin
      chk("timeout2", 32'(q2.size()), 32'd0);
      q2.delete();
    end else begin
      chk("timeout0", 32'(q0.size()), 32'd0);
      q0.delete();
    end
  endtask

  // Present one request for a cycle, queue its expected response, then
  // scramble the request inputs so only latched copies can be used.
  task automatic issue(input int dut, input logic w, input logic [2:0] f3,
                       input logic [11:0] a, input logic [31:0] d,
                       input logic [31:0] exp_d, input logic exp_e, input int lat);
    exp_t e;
    @(negedge clk);
    e.data = exp_d;
    e.err  = exp_e;
    e.cyc  = cyc + lat;
    if (dut == 2) begin
      req2 = 1'b1; we2 = w; f3_2 = f3; addr2 = a[7:0]; dw2 = d;
      q2.push_back(e);
    end else begin
      req0 = 1'b1; we0 = w; f3_0 = f3; addr0 = a; dw0 = d;
      q0.push_back(e);
    end
    @(negedge clk);
    if (dut == 2) begin
      req2 = 1'b0; we2 = ~w; f3_2 = 3'($urandom); addr2 = 8'($urandom); dw2 = $urandom;
    end else begin
      req0 = 1'b0; we0 = ~w; f3_0 = 3'($urandom); addr0 = 12'($urandom); dw0 = $urandom;
    end
    wait_done(dut);
  endtask

  initial begin
    logic [31:0] word10;
    int          rc;
    int          t0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready2", {31'd0, ready2}, 32'd0);
    chk("rst_datar2", datar2, 32'd0);
    chk("rst_err2", {31'd0, err2}, 32'd0);
    chk("rst_ready0", {31'd0, ready0}, 32'd0);
    rst = 1'b0;

    // Word and sub-word accesses, WAIT_CYC=2
    issue(2, 1'b1, F3_W,  12'h010, 32'hDEADBEEF, 32'h00000000, 1'b0, LAT2);
    issue(2, 1'b0, F3_W,  12'h010, 32'h0,        32'hDEADBEEF, 1'b0, LAT2);
    issue(2, 1'b1, F3_B,  12'h011, 32'hAAAAAA80, 32'h00000000, 1'b0, LAT2);
    issue(2, 1'b0, F3_B,  12'h011, 32'h0,        32'hFFFFFF80, 1'b0, LAT2);
    issue(2, 1'b0, F3_BU, 12'h011, 32'h0,        32'h00000080, 1'b0, LAT2);
    issue(2, 1'b0, F3_W,  12'h010, 32'h0,        32'hDEAD80EF, 1'b0, LAT2);
    issue(2, 1'b1, F3_H,  12'h012, 32'h55551234, 32'h00000000, 1'b0, LAT2);
    issue(2, 1'b0, F3_HU, 12'h012, 32'h0,        32'h00001234, 1'b0, LAT2);
    issue(2, 1'b0, F3_W,  12'h010, 32'h0,        32'h123480EF, 1'b0, LAT2);
    issue(2, 1'b0, F3_H,  12'h010, 32'h0,        32'hFFFF80EF, 1'b0, LAT2);
    issue(2, 1'b0, F3_B,  12'h013, 32'h0,        32'h00000012, 1'b0, LAT2);

`ifdef DMEM_WS_FAULT_EN
    // Faults: one-cycle response, err=1, zero data, no write
    issue(2, 1'b0, F3_W,   12'h013, 32'h0,        32'h0, 1'b1, LATF);
    issue(2, 1'b1, F3_BU,  12'h010, 32'h000000FF, 32'h0, 1'b1, LATF);
    issue(2, 1'b0, F3_H,   12'h011, 32'h0,        32'h0, 1'b1, LATF);
    issue(2, 1'b0, 3'b011, 12'h010, 32'h0,        32'h0, 1'b1, LATF);
    issue(2, 1'b1, F3_W,   12'h012, 32'hFFFFFFFF, 32'h0, 1'b1, LATF);
    word10 = 32'h123480EF;
`else
    // No faults: force-alignment and illegal-as-W, full latency
    issue(2, 1'b0, F3_W,   12'h013, 32'h0,        32'h123480EF, 1'b0, LAT2);
    issue(2, 1'b0, F3_H,   12'h011, 32'h0,        32'hFFFF80EF, 1'b0, LAT2);
    issue(2, 1'b0, 3'b011, 12'h012, 32'h0,        32'h123480EF, 1'b0, LAT2);
    issue(2, 1'b1, F3_BU,  12'h011, 32'h0BADCAFE, 32'h00000000, 1'b0, LAT2);
    issue(2, 1'b0, F3_HU,  12'h013, 32'h0,        32'h00000BAD, 1'b0, LAT2);
    word10 = 32'h0BADCAFE;
`endif
    issue(2, 1'b0, F3_W, 12'h010, 32'h0, word10, 1'b0, LAT2);

    // Reset during WAIT drops the store and its ready pulse
    issue(2, 1'b1, F3_W, 12'h020, 32'h00000000, 32'h0, 1'b0, LAT2);
    @(negedge clk);
    req2 = 1'b1; we2 = 1'b1; f3_2 = F3_W; addr2 = 8'h20; dw2 = 32'h00000055;
    @(negedge clk);
    req2 = 1'b0;
    rc = rdy_cnt2;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_ready", {31'd0, ready2}, 32'd0);
    repeat (5) @(negedge clk);
    chk("rst_no_pulse", 32'(rdy_cnt2 - rc), 32'd0);
    issue(2, 1'b0, F3_W, 12'h020, 32'h0, 32'h00000000, 1'b0, LAT2);
    issue(2, 1'b0, F3_W, 12'h010, 32'h0, word10,       1'b0, LAT2);

    // WAIT_CYC=0: wrap-around and one-cycle latency
    issue(0, 1'b1, F3_W, 12'h000, 32'hCAFEF00D, 32'h00000000, 1'b0, LAT0);
    issue(0, 1'b0, F3_W, 12'h100, 32'h0,        32'hCAFEF00D, 1'b0, LAT0);
    issue(0, 1'b1, F3_H, 12'h102, 32'h0000BEEF, 32'h00000000, 1'b0, LAT0);
    issue(0, 1'b0, F3_W, 12'h000, 32'h0,        32'hBEEFF00D, 1'b0, LAT0);

    // req held for 5 cycles: accepted on every second cycle only
    @(negedge clk);
    t0 = cyc;
    req0 = 1'b1; we0 = 1'b0; f3_0 = F3_W; addr0 = 12'h100; dw0 = 32'h0;
    q0.push_back('{data: 32'hBEEFF00D, err: 1'b0, cyc: t0 + 1});
    q0.push_back('{data: 32'hBEEFF00D, err: 1'b0, cyc: t0 + 3});
    q0.push_back('{data: 32'hBEEFF00D, err: 1'b0, cyc: t0 + 5});
    repeat (5) @(negedge clk);
    req0 = 1'b0;
    wait_done(0);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_ws.md
Name: dmem_ws

Overview:
- Parametrised successor to the fixed single-cycle data memory used with the RISC-V core.
- Word-organised, byte-addressed RAM.
- Supports RISC-V sized loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW) through a req/ready handshake.
- Has a programmable number of wait states.
- Sits between the core's load/store path and storage, so the core can be exercised against slow memory.

Parameters:
- ADDR_W, 8, byte-address width.
- DEPTH, 64, number of 32-bit words. Power of two, and DEPTH*4 <= 2**ADDR_W.
- WAIT_CYC, 2, wait states inserted before an access completes. Range 0..15.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- req  in  1  access request. Sampled only in IDLE.
- we  in  1  1 = store, 0 = load.
- funct3  in  3  RISC-V size/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr  in  ADDR_W  byte address.
- dataw  in  32  store data. Right-aligned; low bytes are used for B/H.
- ready  out  1  one-cycle completion pulse.
- datar  out  32  load result, extended to 32 bits. Valid only while ready=1.
- err  out  1  access fault. Valid only while ready=1.

Interface decisions:
- One clock, clk.
- Reset rst is synchronous and active-high.

Behaviour:
- Reset values: ready=0, datar=0, err=0, FSM=IDLE, wait counter=0.
  - RAM contents are not cleared by reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On req=1, latch we, funct3, addr and dataw.
  - Word index = addr[log2(DEPTH)+1:2]. Higher address bits are ignored, so addresses wrap modulo DEPTH*4.
  - Fault check: an illegal funct3 (011, 110, 111, or 1xx with we=1) or a misaligned address (H/HU with addr[0]=1; W with addr[1:0]!=0) is a fault.
  - Fault -> RESP, skipping the wait states.
  - Otherwise -> WAIT with counter=WAIT_CYC; when WAIT_CYC=0, go directly to the commit step.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 0: perform the access and go to RESP.
    - Store: byte-lane write. B writes lane addr[1:0]; H writes lanes {addr[1],0} and {addr[1],1}; W writes all 4 lanes. Other lanes are untouched.
    - Load: select the lane(s), then sign-extend (B/H) or zero-extend (BU/HU) into datar.
- RESP:
  - ready=1 for exactly one cycle, then back to IDLE.
  - For stores, datar=0.
  - For faults, err=1, datar=0, and no RAM write occurs.
- Latency: req accepted at edge N -> ready high in cycle N+WAIT_CYC+1. Fault: ready in cycle N+1.
- Back-to-back: the earliest next acceptance is the cycle after ready. req while in WAIT or RESP is ignored and not queued.
- A store commits at the edge entering RESP. A load in a later transaction returns the new data.
- Reset mid-operation: an uncommitted store is dropped, the FSM returns to IDLE, and no ready pulse is produced.
- Request inputs may change after acceptance; only the latched copies are used.

Optional Feature:
- Macro: DMEM_WS_FAULT_EN.
- Defined: fault checking as described above; err is driven.
- Undefined:
  - err is tied to 0.
  - Misaligned addresses are force-aligned: H clears addr[0]; W clears addr[1:0].
  - Illegal funct3 is treated as W.
  - Every access takes the full WAIT_CYC latency.

Decomposition:
- Shared package dmem_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - FSM state encoding (ST_IDLE, ST_WAIT, ST_RESP).
- One natural sub-module, dmem_lane: a combinational load extract/extend and store byte-enable/data-replicate unit, reused by the future cache.
- FSM, counter and RAM array live in dmem_ws.

Test Plan:
- WAIT_CYC=2: SW addr=0x10 data=0xDEADBEEF, then LW 0x10 -> each ready arrives 3 cycles after acceptance; datar=0xDEADBEEF, err=0.
- SB addr=0x11 data=0x80, then LB 0x11 -> datar=0xFFFFFF80. LBU 0x11 -> 0x00000080. LW 0x10 -> 0xDEAD80EF.
- SH addr=0x12 data=0x1234 over 0xDEAD80EF, then LHU 0x12 -> 0x00001234 and LW 0x10 -> 0x123480EF.
- DMEM_WS_FAULT_EN defined: LW 0x13 and SB with funct3=100 -> ready in 1 cycle, err=1, datar=0; a subsequent LW 0x10 shows the data unchanged.
- rst pulsed during WAIT of SW 0x20 data=0x55 (word previously 0) -> no ready pulse; LW 0x20 after reset -> 0x00000000.
- WAIT_CYC=0 and DEPTH=64: LW 0x100 wraps to word 0 with ready 1 cycle after acceptance; req held high for 5 cycles -> only every second cycle is accepted.
